// File: rtl/systolic_feeder_4x4.sv
// Operand feeder for a 4x4 output-stationary systolic array: stores A and B,
// then streams skewed rows of A west-to-east and skewed columns of B north-to-south.
module systolic_feeder_4x4 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          arr_rst,
  output logic [DW-1:0] out_west0,
  output logic [DW-1:0] out_west4,
  output logic [DW-1:0] out_west8,
  output logic [DW-1:0] out_west12,
  output logic [DW-1:0] out_north0,
  output logic [DW-1:0] out_north1,
  output logic [DW-1:0] out_north2,
  output logic [DW-1:0] out_north3
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t        state, state_n;
  logic [3:0]    slot, slot_n;
  logic [DW-1:0] a_mem [4][4];
  logic [DW-1:0] b_mem [4][4];
  logic [DW-1:0] west_d [4];
  logic [DW-1:0] north_d [4];
  logic [DW-1:0] west_p0 [4];
  logic [DW-1:0] north_p0 [4];
  logic [4:0]    kr;
  logic [4:0]    kc;

  always_comb begin
    state_n = state;
    slot_n  = slot;
    case (state)
      IDLE:   if (start) state_n = CLEAR;
      CLEAR:  begin
        state_n = STREAM;
        slot_n  = 4'd0;
      end
      STREAM: begin
        if (slot == 4'd6) begin
          state_n = DRAIN;
          slot_n  = 4'd0;
        end else begin
          slot_n = slot + 4'd1;
        end
      end
      DRAIN:  begin
        if (slot == 4'd2) state_n = DONE;
        else              slot_n  = slot + 4'd1;
      end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand values are computed for the coming cycle so the outputs are registered.
  always_comb begin
    kr = '0;
    kc = '0;
    for (int r = 0; r < 4; r++) begin
      west_d[r]  = '0;
      north_d[r] = '0;
    end
    if (state_n == STREAM) begin
      for (int r = 0; r < 4; r++) begin
        kr = {1'b0, slot_n} - 5'(r);
        if (kr <= 5'd3) west_d[r] = a_mem[r][kr[1:0]];
        kc = {1'b0, slot_n} - 5'(r);
        if (kc <= 5'd3) north_d[r] = b_mem[kc[1:0]][r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      arr_rst <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        west_p0[r]  <= '0;
        north_p0[r] <= '0;
        for (int c = 0; c < 4; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else begin
      state   <= state_n;
      slot    <= slot_n;
      busy    <= (state_n == CLEAR) || (state_n == STREAM) || (state_n == DRAIN);
      done    <= (state_n == DONE);
      arr_rst <= (state_n == CLEAR);
      for (int r = 0; r < 4; r++) begin
        west_p0[r]  <= west_d[r];
        north_p0[r] <= north_d[r];
      end
      if (wr_en && state == IDLE) begin
        if (wr_sel) b_mem[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
        else        a_mem[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
      end
    end
  end

  assign out_west0  = west_p0[0];
  assign out_west4  = west_p0[1];
  assign out_west8  = west_p0[2];
  assign out_west12 = west_p0[3];
  assign out_north0 = north_p0[0];
  assign out_north1 = north_p0[1];
  assign out_north2 = north_p0[2];
  assign out_north3 = north_p0[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Bench for systolic_feeder_4x4: cycle-accurate behavioural model, an attached
// 4x4 multiply-accumulate array, directed scenarios and a randomized phase.
module tb_systolic_feeder_4x4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, wr_en, wr_sel, start;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, arr_rst;
  logic [DW-1:0] out_west0, out_west4, out_west8, out_west12;
  logic [DW-1:0] out_north0, out_north1, out_north2, out_north3;
  logic [DW-1:0] wo [4];
  logic [DW-1:0] no [4];

  int checks = 0;
  int errors = 0;

  systolic_feeder_4x4 #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .arr_rst(arr_rst),
    .out_west0(out_west0), .out_west4(out_west4), .out_west8(out_west8),
    .out_west12(out_west12), .out_north0(out_north0), .out_north1(out_north1),
    .out_north2(out_north2), .out_north3(out_north3)
  );

  always #5 clk = ~clk;

  assign wo[0] = out_west0;
  assign wo[1] = out_west4;
  assign wo[2] = out_west8;
  assign wo[3] = out_west12;
  assign no[0] = out_north0;
  assign no[1] = out_north1;
  assign no[2] = out_north2;
  assign no[3] = out_north3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age counts cycles since the accepted start (0 = idle, 12 = done cycle).
  int            m_age = 0;
  bit            m_valid = 0;
  logic [DW-1:0] ma [4][4];
  logic [DW-1:0] mb [4][4];

  always @(posedge clk) begin
    if (rst) begin
      m_age = 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ma[i][j] = '0;
          mb[i][j] = '0;
        end
    end else if (m_age == 0) begin
      if (wr_en) begin
        if (wr_sel) mb[wr_addr / 4][wr_addr % 4] = wr_data;
        else        ma[wr_addr / 4][wr_addr % 4] = wr_data;
      end
      if (start) m_age = 1;
    end else if (m_age == 12) begin
      m_age = 0;
    end else begin
      m_age++;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int t;
      logic [DW-1:0] ew, en;
      t = m_age - 2;
      chk("busy", busy, (m_age >= 1 && m_age <= 11));
      chk("done", done, (m_age == 12));
      chk("arr_rst", arr_rst, (m_age == 1));
      for (int r = 0; r < 4; r++) begin
        ew = '0;
        en = '0;
        if (m_age >= 2 && m_age <= 8) begin
          if (t - r >= 0 && t - r <= 3) ew = ma[r][t - r];
          if (t - r >= 0 && t - r <= 3) en = mb[t - r][r];
        end
        chk($sformatf("west[%0d]", 4 * r), wo[r], ew);
        chk($sformatf("north[%0d]", r), no[r], en);
      end
    end
  end

  // Attached array: operands hop one PE per cycle; accumulators cleared by arr_rst.
  logic [DW-1:0] pw [4][4];
  logic [DW-1:0] pn [4][4];
  logic [DW-1:0] acc [4][4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [DW-1:0] win, nin;
        if (j == 0) win = wo[i]; else win = pw[i][(j > 0) ? j - 1 : 0];
        if (i == 0) nin = no[j]; else nin = pn[(i > 0) ? i - 1 : 0][j];
        pw[i][j]  <= win;
        pn[i][j]  <= nin;
        acc[i][j] <= arr_rst ? '0 : acc[i][j] + win * nin;
      end
  end

  logic [DW-1:0] r_w0, r_n3a, r_n3b, r_w4;
  int  ndone, dcyc;
  bit  busy_ok, zero_ok;

  task automatic wr(input logic s, input logic [3:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Caller raises start; n counts cycles after the edge that samples it.
  task automatic run_watch(input int s1, input int s2, input int wr99, input int rstc);
    ndone = 0; dcyc = -1; busy_ok = 1; zero_ok = 1;
    r_w0 = 'x; r_n3a = 'x; r_n3b = 'x; r_w4 = 'x;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      start = 0; wr_en = 0; rst = 0;
      if (n == 2) r_w0 = out_west0;
      if (n == 5) begin r_n3a = out_north3; r_w4 = out_west4; end
      if (n == 8) r_n3b = out_north3;
      if (done) begin ndone++; dcyc = n; end
      if (n <= 11 && !busy) busy_ok = 0;
      if (rstc != 0 && n == rstc + 1) begin
        if (busy || done || arr_rst) zero_ok = 0;
        for (int r = 0; r < 4; r++) if (wo[r] != 0 || no[r] != 0) zero_ok = 0;
      end
      if (n == s1 || n == s2) start = 1;
      if (n == wr99) begin wr_en = 1; wr_sel = 0; wr_addr = 4'd0; wr_data = 99; end
      if (n == rstc) rst = 1;
    end
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; start = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset west0", out_west0, 0);
    rst = 0;
    @(negedge clk);

    // Identity A, B[i][j] = 4i+j+1: array result must reproduce B.
    for (int i = 0; i < 16; i++) begin
      wr(0, 4'(i), (i / 4 == i % 4) ? 1 : 0);
      wr(1, 4'(i), DW'(i + 1));
    end
    start = 1;
    run_watch(0, 0, 0, 0);
    chk("t1 west0 slot0", r_w0, 1);
    chk("t1 north3 slot3", r_n3a, 4);
    chk("t1 north3 slot6", r_n3b, 16);
    chk("t1 done cycle", dcyc, 12);
    chk("t1 done count", ndone, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("t1 acc[%0d][%0d]", i, j), acc[i][j], 4 * i + j + 1);

    // All elements 2: every result 16.
    for (int i = 0; i < 16; i++) begin
      wr(0, 4'(i), 2);
      wr(1, 4'(i), 2);
    end
    start = 1;
    run_watch(0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("t2 acc[%0d][%0d]", i, j), acc[i][j], 16);

    // Starts mid-run are ignored.
    start = 1;
    run_watch(3, 8, 0, 0);
    chk("t3 done count", ndone, 1);
    chk("t3 done cycle", dcyc, 12);
    chk("t3 busy held", busy_ok, 1);

    // Writes while busy are dropped.
    start = 1;
    run_watch(0, 0, 4, 0);
    chk("t4 west0 during", r_w0, 2);
    start = 1;
    run_watch(0, 0, 0, 0);
    chk("t4 west0 readback", r_w0, 2);

    // Reset in slot 4 aborts the run and clears the operands.
    start = 1;
    run_watch(0, 0, 0, 6);
    chk("t5 zero after rst", zero_ok, 1);
    chk("t5 no done", ndone, 0);
    start = 1;
    run_watch(0, 0, 0, 0);
    chk("t5 west0 zero", r_w0, 0);
    chk("t5 acc[3][3]", acc[3][3], 0);
    chk("t5 acc[0][0]", acc[0][0], 0);

    // Write and start in the same idle cycle.
    wr_en = 1; wr_sel = 0; wr_addr = 4'd6; wr_data = 7; start = 1;
    run_watch(0, 0, 0, 0);
    chk("t6 west4 slot3", r_w4, 7);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 99) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_sel  = $urandom_range(0, 1) == 1;
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      start   = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst = 0; wr_en = 0; start = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
